// File: rtl/ram_read.sv
// ram_read: AXI4 single-beat byte read initiator with a one-word line buffer invalidated by write snooping.
module ram_read #(
   parameter bit LINE_BUF = 1'b1
) (
   input  logic        clk_memory,
   input  logic        aresetn,
   output logic        ARVALID,
   input  logic        ARREADY,
   output logic [26:0] ARADDR,
   output logic [3:0]  ARCACHE,
   output logic [2:0]  ARPROT,
   output logic [7:0]  ARLEN,
   output logic [1:0]  ARBURST,
   output logic        ARLOCK,
   output logic [3:0]  ARQOS,
   output logic [3:0]  ARREGION,
   output logic [2:0]  ARSIZE,
   input  logic        RVALID,
   output logic        RREADY,
   input  logic [63:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic [20:0] addr,
   input  logic        en,
   output logic [7:0]  data,
   output logic        ready,
   output logic        data_valid,
   output logic        err,
   input  logic [20:0] snoop_addr,
   input  logic        snoop_write
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;
   state_t state_q, state_d;
   logic arvalid_q, arvalid_d, rready_q, rready_d, err_q, err_d, line_ok_q, line_ok_d;
   logic [26:0] araddr_q, araddr_d;
   logic [7:0] data_q, data_d;
   logic [63:0] line_q, line_d;
   logic [17:0] tag_q, tag_d;
   logic kill, hit, fill, unused;
   function automatic logic [7:0] lane(input logic [63:0] w, input logic [2:0] b);
      return w[{b, 3'b000} +: 8];
   endfunction
   assign kill = snoop_write && snoop_addr[20:3] == tag_q;
   assign hit = line_ok_q && tag_q == addr[20:3] && !kill;
   assign fill = state_q == DATA && RVALID && rready_q;
   assign unused = &{1'b0, RLAST, snoop_addr[2:0]};
   always_comb begin
      state_d = state_q;
      arvalid_d = arvalid_q;
      rready_d = rready_q;
      araddr_d = araddr_q;
      data_d = data_q;
      err_d = err_q;
      line_d = line_q;
      tag_d = tag_q;
      line_ok_d = line_ok_q;
      case (state_q)
         IDLE: if (en && hit) begin
            data_d = lane(line_q, addr[2:0]);
            state_d = WAIT;
         end else if (en) begin
            araddr_d = {6'b0, addr[20:3], 3'b000};
            arvalid_d = 1'b1;
            state_d = ADDR;
         end
         ADDR: if (arvalid_q && ARREADY) begin
            arvalid_d = 1'b0;
            rready_d = 1'b1;
            state_d = DATA;
         end
         DATA: if (fill) begin
            rready_d = 1'b0;
            line_d = RDATA;
            tag_d = addr[20:3];
            data_d = lane(RDATA, addr[2:0]);
            err_d = RRESP != 2'b00;
            line_ok_d = RRESP == 2'b00 && !(snoop_write && snoop_addr[20:3] == addr[20:3]);
            state_d = WAIT;
         end
         WAIT: state_d = en ? WAIT : IDLE;
         default: state_d = IDLE;
      endcase
      // a snoop hit on the old tag wins over any fill landing on the same edge
      if (kill || !LINE_BUF) line_ok_d = 1'b0;
   end
   always_ff @(posedge clk_memory or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         arvalid_q <= 1'b0;
         rready_q <= 1'b0;
         araddr_q <= '0;
         data_q <= '0;
         err_q <= 1'b0;
         line_q <= '0;
         tag_q <= '0;
         line_ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         arvalid_q <= arvalid_d;
         rready_q <= rready_d;
         araddr_q <= araddr_d;
         data_q <= data_d;
         err_q <= err_d;
         line_q <= line_d;
         tag_q <= tag_d;
         line_ok_q <= line_ok_d;
      end
   end
   assign ARVALID = arvalid_q;
   assign RREADY = rready_q;
   assign ARADDR = araddr_q;
   assign ARCACHE = 4'b0011;
   assign ARPROT = 3'b000;
   assign ARLEN = 8'h00;
   assign ARBURST = 2'b01;
   assign ARLOCK = 1'b0;
   assign ARQOS = 4'h0;
   assign ARREGION = 4'h0;
   assign ARSIZE = 3'b011;
   assign data = data_q;
   assign err = err_q;
   assign ready = aresetn && state_q == IDLE;
   assign data_valid = state_q == WAIT;
endmodule

// File: tb/tb_ram_read.sv
// tb_ram_read: table vectors, corner sequences and a random run against a cache-level reference model.
module tb_ram_read;
   logic clk_memory = 1'b0, aresetn;
   logic ARVALID, ARREADY, ARLOCK, RVALID, RREADY, RLAST, en, ready, data_valid, err, snoop_write;
   logic [26:0] ARADDR;
   logic [3:0] ARCACHE, ARQOS, ARREGION;
   logic [2:0] ARPROT, ARSIZE;
   logic [7:0] ARLEN, data;
   logic [1:0] ARBURST, RRESP, rresp_cfg;
   logic [63:0] RDATA;
   logic [20:0] addr, snoop_addr;
   logic [63:0] mem [16];
   int n_tests = 0, n_fail = 0, ar_cnt = 0, ar_dly = 0, r_dly = 0;
   typedef struct {
      logic [20:0] a;
      int sm;
      logic [20:0] sa;
      int ad, rd;
      logic [1:0] rr;
      logic hit;
      logic [7:0] d;
      logic e;
   } vec_t;
   vec_t tv [9];
   logic m_valid, m_err;
   logic [17:0] m_tag;
   always #5 clk_memory = ~clk_memory;
   ram_read dut (
      .clk_memory(clk_memory), .aresetn(aresetn),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
      .ARLEN(ARLEN), .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARQOS(ARQOS), .ARREGION(ARREGION),
      .ARSIZE(ARSIZE), .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .addr(addr), .en(en), .data(data), .ready(ready), .data_valid(data_valid), .err(err),
      .snoop_addr(snoop_addr), .snoop_write(snoop_write)
   );
   function automatic logic [7:0] ref_lane(input logic [63:0] w, input logic [2:0] b);
      return 8'(w >> (8 * b));
   endfunction
   function automatic logic [20:0] rand_addr();
      return {($urandom_range(0, 3) == 0) ? 14'h2a5 : 14'h0, 7'($urandom_range(0, 127))};
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask
   // AXI slave: ARREADY after ar_dly waiting cycles, RVALID after r_dly, data from mem by word
   initial begin : responder
      int ph, cnt;
      logic [26:0] seen;
      ph = 0; cnt = 0; seen = '0;
      ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0; RLAST = 1;
      forever begin
         @(negedge clk_memory);
         ARREADY = 0; RVALID = 0;
         if (!aresetn) begin
            ph = 0; cnt = 0;
         end else if (ph == 0 && ARVALID) begin
            if (cnt == ar_dly) begin
               ARREADY = 1; ph = 1; cnt = 0; ar_cnt++; seen = ARADDR;
            end else cnt++;
         end else if (ph == 1 && RREADY) begin
            if (cnt == r_dly) begin
               RVALID = 1; RDATA = mem[seen[6:3]]; RRESP = rresp_cfg; ph = 0; cnt = 0;
            end else cnt++;
         end
      end
   end
   task automatic do_read(input logic [20:0] a, input int sm, input logic [20:0] sa, input int ad,
                          input int rd, input logic [1:0] rr, input logic exp_hit,
                          input logic [7:0] exp_d, input logic exp_e, input string nm);
      int lat, arc0, av, rv;
      logic ar_bad, both;
      ar_dly = ad; r_dly = rd; rresp_cfg = rr;
      if (sm == 1) begin
         snoop_addr = sa; snoop_write = 1;
         @(negedge clk_memory);
         snoop_write = 0;
      end
      arc0 = ar_cnt; lat = 0; av = 0; rv = 0; ar_bad = 0; both = 0;
      addr = a; en = 1;
      if (sm == 2) begin
         snoop_addr = sa; snoop_write = 1;
      end
      while (!data_valid && lat < 100) begin
         @(negedge clk_memory);
         snoop_write = 0;
         lat++;
         if (ARVALID) begin
            av++;
            if (ARADDR !== {6'b0, a[20:3], 3'b000}) ar_bad = 1;
         end
         if (RREADY) rv++;
         if (ARVALID && RREADY) both = 1;
      end
      chk({nm, ".latency"}, lat, exp_hit ? 1 : 3 + ad + rd);
      chk({nm, ".ar_issued"}, ar_cnt - arc0, exp_hit ? 0 : 1);
      chk({nm, ".data"}, data, exp_d);
      chk({nm, ".err"}, err, exp_e);
      chk({nm, ".ready_in_wait"}, ready, 0);
      chk({nm, ".arvalid_cycles"}, av, exp_hit ? 0 : ad + 1);
      chk({nm, ".rready_cycles"}, rv, exp_hit ? 0 : rd + 1);
      chk({nm, ".araddr_stable"}, ar_bad, 0);
      chk({nm, ".ar_r_overlap"}, both, 0);
      repeat (2) @(negedge clk_memory);
      chk({nm, ".hold_valid"}, data_valid, 1);
      chk({nm, ".hold_data"}, data, exp_d);
      chk({nm, ".no_reissue"}, ar_cnt - arc0, exp_hit ? 0 : 1);
      en = 0;
      @(negedge clk_memory);
      chk({nm, ".back_idle"}, {ready, data_valid}, 2'b10);
   endtask
   initial begin
      aresetn = 0; en = 0; addr = '0; snoop_write = 0; snoop_addr = '0; rresp_cfg = '0;
      for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
      mem[2] = 64'h8877665544332211;
      mem[3] = 64'hF0E0D0C0B0A09080;
      mem[4] = 64'h0706050403020100;
      repeat (3) @(negedge clk_memory);
      chk("reset.outputs", {ARVALID, RREADY, ready, data_valid, err}, 5'b0);
      chk("reset.araddr", ARADDR, 0);
      chk("reset.data", data, 0);
      aresetn = 1;
      @(negedge clk_memory);
      chk("idle.ready", ready, 1);
      chk("const.ar", {ARCACHE, ARPROT, ARLEN, ARBURST, ARLOCK, ARQOS, ARREGION, ARSIZE},
          {4'b0011, 3'b000, 8'h00, 2'b01, 1'b0, 4'h0, 4'h0, 3'b011});
      tv[0] = '{21'h13, 0, 21'h0, 0, 0, 2'b00, 1'b0, 8'h44, 1'b0};
      tv[1] = '{21'h16, 0, 21'h0, 0, 0, 2'b00, 1'b1, 8'h77, 1'b0};
      tv[2] = '{21'h10, 1, 21'h11, 0, 0, 2'b00, 1'b0, 8'h11, 1'b0};
      tv[3] = '{21'h10, 0, 21'h0, 0, 0, 2'b00, 1'b1, 8'h11, 1'b0};
      tv[4] = '{21'h12, 2, 21'h10, 0, 0, 2'b00, 1'b0, 8'h33, 1'b0};
      tv[5] = '{21'h1F, 0, 21'h0, 5, 7, 2'b00, 1'b0, 8'hF0, 1'b0};
      tv[6] = '{21'h21, 0, 21'h0, 0, 0, 2'b10, 1'b0, 8'h01, 1'b1};
      tv[7] = '{21'h21, 0, 21'h0, 1, 2, 2'b00, 1'b0, 8'h01, 1'b0};
      tv[8] = '{21'h22, 0, 21'h0, 0, 0, 2'b00, 1'b1, 8'h02, 1'b0};
      for (int i = 0; i < 9; i++)
         do_read(tv[i].a, tv[i].sm, tv[i].sa, tv[i].ad, tv[i].rd, tv[i].rr, tv[i].hit, tv[i].d,
                 tv[i].e, $sformatf("row%0d", i));
      do_read(21'h28, 0, 21'h0, 0, 0, 2'b00, 1'b0, ref_lane(mem[5], 3'd0), 1'b0, "pre_rst");
      ar_dly = 0; r_dly = 20; addr = 21'h30; en = 1;
      for (int i = 0; i < 10 && !RREADY; i++) @(negedge clk_memory);
      chk("rst.in_data", RREADY, 1);
      #1 aresetn = 0;
      #1;
      chk("rst.async_drop", {ARVALID, RREADY, ready, data_valid}, 4'b0);
      chk("rst.data_err", {data, err}, 9'h0);
      en = 0;
      @(negedge clk_memory);
      aresetn = 1;
      #1;
      chk("rst.ready", ready, 1);
      @(negedge clk_memory);
      do_read(21'h28, 0, 21'h0, 0, 0, 2'b00, 1'b0, ref_lane(mem[5], 3'd0), 1'b0, "post_rst");
      m_valid = 1; m_tag = 18'h5; m_err = 0;
      for (int i = 0; i < 150; i++) begin
         logic [20:0] a, sa;
         logic [1:0] rr;
         logic hit;
         int sm;
         a = rand_addr();
         sm = $urandom_range(0, 3) % 3;
         sa = $urandom_range(0, 1) ? {m_tag, 3'($urandom_range(0, 7))} : rand_addr();
         rr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (sm != 0 && sa[20:3] == m_tag) m_valid = 0;
         hit = m_valid && m_tag == a[20:3];
         if (!hit) begin
            m_valid = rr == 2'b00; m_tag = a[20:3]; m_err = rr != 2'b00;
         end
         do_read(a, sm, sa, $urandom_range(0, 3), $urandom_range(0, 3), rr, hit,
                 ref_lane(mem[a[6:3]], a[2:0]), m_err, $sformatf("rnd%0d", i));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
